uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bus-side push port, status flags and sender handshake
// for uart_tx_fifo. The almost_full flag exists only when
// UART_TX_FIFO_WATERMARK_EN is defined.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          txstatus;
  logic          txen;
  logic [7:0]    txdata;
`ifdef UART_TX_FIFO_WATERMARK_EN
  logic          almost_full;

  modport master (
    output wr_en, wr_data, clr_ovf, txstatus,
    input  full, empty, count, overflow, txen, txdata, almost_full
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, txstatus,
    output full, empty, count, overflow, txen, txdata, almost_full
  );
`else
  modport master (
    output wr_en, wr_data, clr_ovf, txstatus,
    input  full, empty, count, overflow, txen, txdata
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, txstatus,
    output full, empty, count, overflow, txen, txdata
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART sender, one frame at a time.
// Optional almost-full flag: define UART_TX_FIFO_WATERMARK_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for data and an idle sender; txdata captured on exit
// LAUNCH    | txen high for this single cycle, head entry popped
// WAIT_BUSY | waiting for the sender to report busy (txstatus == 0)
// WAIT_DONE | waiting for the sender to report idle again (txstatus == 1)
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
`ifdef UART_TX_FIFO_WATERMARK_EN
  , parameter int WATERMARK = 12
`endif
) (
  input logic      sysclk,
  input logic      reset,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          overflow_q;
  logic          txen_q;
  logic [7:0]    txdata_q;
  state_t        state;
  state_t        state_nxt;

  logic full_w;
  logic empty_w;
  logic pop;
  logic push;
  logic reject;
  logic load;

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);
  // The head is captured into txdata on the way into LAUNCH, so the pop in
  // LAUNCH only has to advance the read pointer; a push into a full FIFO in
  // that cycle may safely overwrite the slot just vacated.
  assign pop     = (state == LAUNCH);
  assign push    = bus.wr_en && (!full_w || pop);
  assign reject  = bus.wr_en && full_w && !pop;

  // Drain FSM next-state decode; load marks the IDLE->LAUNCH transition.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_w && bus.txstatus) begin
          state_nxt = LAUNCH;
          load      = 1'b1;
        end
      end
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!bus.txstatus) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.txstatus)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Occupancy arithmetic: simultaneous push and pop leave count unchanged.
  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // Pointers, occupancy and sticky overflow (a rejected push beats clr_ovf).
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      if (reject)           overflow_q <= 1'b1;
      else if (bus.clr_ovf) overflow_q <= 1'b0;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // Sender-facing outputs: txdata held from one launch to the next.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      txen_q   <= 1'b0;
      txdata_q <= 8'h00;
    end else begin
      txen_q <= load;
      if (load) txdata_q <= mem[rd_ptr];
    end
  end

`ifdef UART_TX_FIFO_WATERMARK_EN
  localparam logic [AW:0] WM_CNT = (AW+1)'(WATERMARK);
  logic almost_full_q;

  // Almost-full tracks the registered count on the same edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) almost_full_q <= 1'b0;
    else       almost_full_q <= (count_nxt >= WM_CNT);
  end

  assign bus.almost_full = almost_full_q;
`endif

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.txen     = txen_q;
  assign bus.txdata   = txdata_q;

endmodule
